ita_act_packer: RTL and testbench
=================================

Name: ita_act_packer

Overview:
- Sits directly downstream of ita_gelu.
- Consumes one signed WI-bit post-activation value per handshake.
- Packs N_PE consecutive values into one output word for the output buffer / write-back path.
- Tracks tile length, zero-pads and strobes a final partial word, flags the last word, and pulses completion.

Parameters:
- N_PE, 16, lanes per output word.
- WI, 8, element width in bits (signed).
- LEN_W, 16, width of the tile element count.
- FIFO_DEPTH, 2, output word buffer entries (>=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  tile start pulse; samples len_i
- len_i  in  LEN_W  number of elements in the tile
- busy_o  out  1  high from accepted start until done
- valid_i  in  1  input element valid
- ready_o  out  1  input element ready
- data_i  in  WI  signed post-activation element
- valid_o  out  1  output word valid
- ready_i  in  1  output word ready
- data_o  out  N_PE*WI  packed word; lane 0 in LSBs
- strb_o  out  N_PE  per-lane valid mask
- last_o  out  1  word is the final one of the tile
- done_o  out  1  one-cycle tile completion pulse

Behaviour:
- Interface: single clock clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, lane/element counters 0, FIFO empty.
- FSM IDLE:
  - start_i with len_i>0 -> RUN; latch len_i, clear counters.
  - start_i with len_i==0 -> stay IDLE; done_o pulses the next cycle; no words are produced.
- FSM RUN:
  - ready_o = (fifo_count < FIFO_DEPTH). This is registered-count based, with no combinational path from ready_i.
  - Each handshake writes data_i into lane lane_q of the pack register, increments lane_q and elem_q, and sets the lane strobe.
  - Word completes when lane_q == N_PE-1 or elem_q == len-1. Push the word with strobe and last = (elem_q == len-1). Clear the pack register and lane_q.
  - After pushing the last word -> DRAIN. ready_o = 0.
- FSM DRAIN: when the last word handshakes on the output, pulse done_o in the same cycle, then -> IDLE.
- busy_o = (state != IDLE).
- start_i while busy is ignored.
- Partial final word: unfilled lanes are 0 and their strb_o bits are 0.
- Latency: valid_o rises the cycle after the completing input handshake (FIFO is registered).
- Output: valid_o = FIFO non-empty; data_o, strb_o and last_o reflect the FIFO head and hold stable while valid_o && !ready_i.
- Simultaneous push and pop on a full FIFO is not possible, because ready_o is already 0 when full.
- Throughput: with ready_i held high, 1 element/cycle with no bubbles.
- Counters: elem_q wraps never; len is bounded by LEN_W.
- Reset mid-tile: pack register, FIFO and counters are discarded; no done_o.

Optional Feature:
- Macro: ITA_ACT_PACKER_CLIP_COUNT_EN.
- Defined:
  - Adds output port clip_cnt_o [LEN_W-1:0], counting accepted elements equal to -2^(WI-1) or 2^(WI-1)-1 in the current tile.
  - Cleared on an accepted start; holds after done until the next start.
  - Saturates at all-ones.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- ita_package additions:
  - ACT_LEN_W constant.
  - act_word_t (N_PE x WI signed packed array).
  - act_strb_t (logic [N_PE-1:0]).
  - act_state_e (IDLE, RUN, DRAIN).
  - Reuses existing WI and N_PE.
- Sub-module ita_act_out_fifo:
  - Parameterised depth, stores {last, strb, word}.
  - Synchronous active-high reset.
  - Exposes count, push, pop and head.

Test Plan:
- len=64, N_PE=16, inputs 0..63, ready_i=1 -> 4 words.
  - Word0 lane k = k.
  - strb all 1s on every word.
  - last_o only on word 3.
  - done_o pulses with word 3's handshake.
  - ready_o stays high for 64 consecutive cycles.
- len=20, inputs all -1 -> word0 strb=16'hFFFF; word1 lanes 0-3 = -1, lanes 4-15 = 0, strb=16'h000F, last=1.
- len=64, ready_i=0 for 40 cycles then 1:
  - After 32 accepted elements (FIFO full) ready_o=0.
  - valid_o/data_o stable while stalled.
  - All 4 words delivered in order with no loss.
- start_i with len=0 -> done_o one cycle later, valid_o never asserts, busy_o stays 0.
- rst_i asserted after 10 of 64 elements -> next cycle all outputs 0.
  - A fresh start with len=16 yields exactly one correct word.
- With ITA_ACT_PACKER_CLIP_COUNT_EN, len=16 containing three 127s and two -128s -> clip_cnt_o=5 at done_o.

Source files
------------

// File: rtl/ita_act_packer_pkg.sv
// Shared constants and types for the activation packer that follows ita_gelu.
// Defaults here match the ita datapath: 16 lanes of signed 8-bit activations.
package ita_act_packer_pkg;

    localparam int ACT_N_PE       = 16;
    localparam int ACT_WI         = 8;
    localparam int ACT_LEN_W      = 16;
    localparam int ACT_FIFO_DEPTH = 2;

    typedef logic signed [ACT_WI-1:0] act_elem_t;
    typedef act_elem_t [ACT_N_PE-1:0] act_word_t;
    typedef logic [ACT_N_PE-1:0]      act_strb_t;

    typedef enum logic [1:0] {
        ACT_IDLE  = 2'd0,
        ACT_RUN   = 2'd1,
        ACT_DRAIN = 2'd2
    } act_state_e;

    // Index width that stays legal when a dimension collapses to one entry.
    function automatic int act_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ita_act_out_fifo.sv
// Small registered FIFO holding packed output words as {last, strb, word}.
// Head is read combinationally from the storage array; count is registered.
module ita_act_out_fifo
    import ita_act_packer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 din_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = act_idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push_i) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
            if (pop_i)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; only the pointers and count define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr] <= din_i;
    end

    assign head_o  = r_mem[r_rd];
    assign count_o = r_count;

endmodule

// File: rtl/ita_act_packer.sv
// Packs N_PE signed activations per output word, strobing and flagging the tile tail.
// Optional macro ITA_ACT_PACKER_CLIP_COUNT_EN adds clip_cnt_o (saturated-value counter).
module ita_act_packer
    import ita_act_packer_pkg::*;
#(
    parameter int N_PE       = ACT_N_PE,
    parameter int WI         = ACT_WI,
    parameter int LEN_W      = ACT_LEN_W,
    parameter int FIFO_DEPTH = ACT_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       len_i,
    output logic                   busy_o,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic signed [WI-1:0]   data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [N_PE*WI-1:0]     data_o,
    output logic [N_PE-1:0]        strb_o,
    output logic                   last_o,
    output logic                   done_o
`ifdef ITA_ACT_PACKER_CLIP_COUNT_EN
   ,output logic [LEN_W-1:0]       clip_cnt_o
`endif
);

    localparam int LANE_W = act_idx_w(N_PE);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int FW     = 1 + N_PE + N_PE * WI;

    localparam logic [1:0] S_IDLE  = ACT_IDLE;
    localparam logic [1:0] S_RUN   = ACT_RUN;
    localparam logic [1:0] S_DRAIN = ACT_DRAIN;

    logic [1:0]          r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_elem;
    logic [LANE_W-1:0]   r_lane;
    logic [N_PE*WI-1:0]  r_pack;
    logic [N_PE-1:0]     r_strb;
    logic                r_done_zero;

    logic                w_start_ok;
    logic                w_accept;
    logic                w_is_last;
    logic                w_word_done;
    logic                w_push;
    logic                w_pop;
    logic [N_PE*WI-1:0]  w_pack_nxt;
    logic [N_PE-1:0]     w_strb_nxt;
    logic [FW-1:0]       w_din;
    logic [FW-1:0]       w_head;
    logic [CW-1:0]       w_fifo_count;

    assign w_start_ok  = start_i && (r_state == S_IDLE);
    assign ready_o     = (r_state == S_RUN) && (w_fifo_count < CW'(FIFO_DEPTH));
    assign w_accept    = valid_i && ready_o;
    assign w_is_last   = (r_elem == r_len - LEN_W'(1));
    assign w_word_done = (r_lane == LANE_W'(N_PE - 1)) || w_is_last;

    // NOTE: every always_comb output is assigned a default first, so no
    // path through the block can leave a latch behind.
    always_comb begin
        w_pack_nxt                  = r_pack;
        w_strb_nxt                  = r_strb;
        w_pack_nxt[r_lane*WI +: WI] = data_i;
        w_strb_nxt[r_lane]          = 1'b1;
    end

    assign w_push = w_accept && w_word_done;
    assign w_din  = {w_is_last, w_strb_nxt, w_pack_nxt};
    assign w_pop  = valid_o && ready_i;

    ita_act_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FW)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .din_i   (w_din),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .count_o (w_fifo_count)
    );

    // Head is masked while empty so unwritten storage never reaches the pins.
    assign valid_o                  = (w_fifo_count != '0);
    assign {last_o, strb_o, data_o} = valid_o ? w_head : '0;
    assign busy_o                   = (r_state != S_IDLE);
    assign done_o                   = r_done_zero || ((r_state == S_DRAIN) && w_pop && last_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_elem      <= '0;
            r_lane      <= '0;
            r_pack      <= '0;
            r_strb      <= '0;
            r_done_zero <= 1'b0;
        end else begin
            r_done_zero <= w_start_ok && (len_i == '0);
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok && (len_i != '0)) begin
                        r_state <= S_RUN;
                        r_len   <= len_i;
                        r_elem  <= '0;
                        r_lane  <= '0;
                        r_pack  <= '0;
                        r_strb  <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_elem <= r_elem + LEN_W'(1);
                        if (w_word_done) begin
                            r_pack <= '0;
                            r_strb <= '0;
                            r_lane <= '0;
                            if (w_is_last) r_state <= S_DRAIN;
                        end else begin
                            r_pack <= w_pack_nxt;
                            r_strb <= w_strb_nxt;
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && last_o) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ITA_ACT_PACKER_CLIP_COUNT_EN
    localparam logic [WI-1:0] MIN_V = {1'b1, {(WI-1){1'b0}}};
    localparam logic [WI-1:0] MAX_V = {1'b0, {(WI-1){1'b1}}};

    logic [LEN_W-1:0] r_clip;
    logic             w_clip_hit;

    assign w_clip_hit = (data_i == MIN_V) || (data_i == MAX_V);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clip <= '0;
        end else if (w_start_ok) begin
            r_clip <= '0;
        end else if (w_accept && w_clip_hit && (r_clip != '1)) begin
            r_clip <= r_clip + LEN_W'(1);
        end
    end

    assign clip_cnt_o = r_clip;
`endif

endmodule

// File: tb/tb_ita_act_packer.sv
// Self-checking bench for ita_act_packer: directed tiles plus randomized tiles
// compared against a word-level model built from the element list.
module tb_ita_act_packer;

    localparam int N_PE  = 16;
    localparam int WI    = 8;
    localparam int LEN_W = 16;

    logic                  clk_i;
    logic                  rst_i;
    logic                  start_i;
    logic [LEN_W-1:0]      len_i;
    logic                  busy_o;
    logic                  valid_i;
    logic                  ready_o;
    logic signed [WI-1:0]  data_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [N_PE*WI-1:0]    data_o;
    logic [N_PE-1:0]       strb_o;
    logic                  last_o;
    logic                  done_o;
`ifdef ITA_ACT_PACKER_CLIP_COUNT_EN
    logic [LEN_W-1:0]      clip_cnt_o;
`endif

    ita_act_packer dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .len_i   (len_i),
        .busy_o  (busy_o),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .strb_o  (strb_o),
        .last_o  (last_o),
        .done_o  (done_o)
`ifdef ITA_ACT_PACKER_CLIP_COUNT_EN
       ,.clip_cnt_o (clip_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [WI-1:0] elems[$];
    logic [N_PE*WI-1:0]   exp_data[$], got_data[$];
    logic [N_PE-1:0]      exp_strb[$], got_strb[$];
    bit                   exp_last[$], got_last[$];

    int               done_cnt, max_ready_run, stable_err, acc_at_stall;
    bit               rdy_at_stall, done_on_last, timed_out;
    logic [LEN_W-1:0] clip_at_done;

    // Reference: slice the element list into N_PE-wide words, zero-filling the tail.
    task automatic build_model(input int len);
        logic [N_PE*WI-1:0] w;
        logic [N_PE-1:0]    s;
        exp_data.delete(); exp_strb.delete(); exp_last.delete();
        for (int wi = 0; wi * N_PE < len; wi++) begin
            w = '0;
            s = '0;
            for (int k = 0; k < N_PE; k++) begin
                if (wi * N_PE + k < len) begin
                    w[k*WI +: WI] = elems[wi * N_PE + k];
                    s[k]          = 1'b1;
                end
            end
            exp_data.push_back(w);
            exp_strb.push_back(s);
            exp_last.push_back((wi + 1) * N_PE >= len);
        end
    endtask

    task automatic fill_random(input int len);
        elems.delete();
        for (int i = 0; i < len; i++) elems.push_back(WI'($urandom));
    endtask

    // Drives one tile and records what the DUT emits; entered and left #1 after posedge.
    task automatic run_tile(input int len, input int stall, input bit rand_gaps, input bit rand_ready);
        int idx = 0;
        int cyc = 0;
        int run = 0;
        bit fin = 0;
        bit acc;
        bit held = 0;
        logic [N_PE*WI-1:0] held_d;
        logic [N_PE-1:0]    held_s;
        got_data.delete(); got_strb.delete(); got_last.delete();
        done_cnt = 0; max_ready_run = 0; stable_err = 0; acc_at_stall = -1;
        rdy_at_stall = 1'b1; done_on_last = 1'b0; clip_at_done = '0;
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (!fin && cyc < 4000) begin
            valid_i = (idx < len) && (!rand_gaps || $urandom_range(3) != 0);
            data_i  = (idx < len) ? elems[idx] : '0;
            ready_i = (cyc >= stall) && (!rand_ready || $urandom_range(2) != 0);
            @(negedge clk_i);
            acc = valid_i && ready_o;
            run = ready_o ? run + 1 : 0;
            if (run > max_ready_run) max_ready_run = run;
            if (held && (valid_o !== 1'b1 || data_o !== held_d || strb_o !== held_s)) stable_err++;
            held   = valid_o && !ready_i;
            held_d = data_o;
            held_s = strb_o;
            if (stall > 0 && cyc == stall - 1) begin
                acc_at_stall = idx;
                rdy_at_stall = ready_o;
            end
            if (valid_o && ready_i) begin
                got_data.push_back(data_o);
                got_strb.push_back(strb_o);
                got_last.push_back(last_o);
            end
            if (done_o) begin
                done_cnt++;
                done_on_last = valid_o && ready_i && last_o;
`ifdef ITA_ACT_PACKER_CLIP_COUNT_EN
                clip_at_done = clip_cnt_o;
`endif
                fin = 1'b1;
            end
            @(posedge clk_i); #1;
            if (acc) idx++;
            cyc++;
        end
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        timed_out = !fin;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if ({valid_o, ready_o, busy_o, done_o, last_o, strb_o, data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b r=%0b busy=%0b done=%0b last=%0b strb=%h data=%h, want all 0",
                     valid_o, ready_o, busy_o, done_o, last_o, strb_o, data_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_full_tile();
        elems.delete();
        for (int i = 0; i < 64; i++) elems.push_back(WI'(i));
        build_model(64);
        run_tile(64, 0, 1'b0, 1'b0);
        n_tests++;
        if (timed_out || got_data.size() != 4) begin
            n_fail++;
            $display("FAIL full_count: got %0d words (timeout=%0b), want 4", got_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_tests++;
            if ({got_last[i], got_strb[i], got_data[i]} !== {exp_last[i], exp_strb[i], exp_data[i]}) begin
                n_fail++;
                $display("FAIL full_word%0d: got last=%0b strb=%h data=%h, want last=%0b strb=%h data=%h",
                         i, got_last[i], got_strb[i], got_data[i], exp_last[i], exp_strb[i], exp_data[i]);
            end
        end
        n_tests++;
        if (done_cnt != 1 || !done_on_last) begin
            n_fail++;
            $display("FAIL full_done: got pulses=%0d with_last=%0b, want 1 and 1", done_cnt, done_on_last);
        end
        n_tests++;
        if (max_ready_run != 64) begin
            n_fail++;
            $display("FAIL full_ready_run: got %0d consecutive ready cycles, want 64", max_ready_run);
        end
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after: got busy=%0b done=%0b valid=%0b, want 0 0 0", busy_o, done_o, valid_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_partial();
        logic [N_PE*WI-1:0] want_w1;
        elems.delete();
        for (int i = 0; i < 20; i++) elems.push_back(-8'sd1);
        build_model(20);
        run_tile(20, 0, 1'b0, 1'b0);
        want_w1 = '0;
        want_w1[4*WI-1:0] = '1;
        n_tests++;
        if (timed_out || got_data.size() != 2) begin
            n_fail++;
            $display("FAIL partial_count: got %0d words (timeout=%0b), want 2", got_data.size(), timed_out);
        end else begin
            n_tests++;
            if (got_strb[0] !== 16'hFFFF || got_last[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL partial_w0: got strb=%h last=%0b, want ffff 0", got_strb[0], got_last[0]);
            end
            n_tests++;
            if ({got_last[1], got_strb[1], got_data[1]} !== {1'b1, 16'h000F, want_w1}) begin
                n_fail++;
                $display("FAIL partial_w1: got last=%0b strb=%h data=%h, want last=1 strb=000f data=%h",
                         got_last[1], got_strb[1], got_data[1], want_w1);
            end
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL partial_done: got %0d pulses, want 1", done_cnt);
        end
    endtask

    task automatic test_stall();
        fill_random(64);
        build_model(64);
        run_tile(64, 40, 1'b0, 1'b0);
        n_tests++;
        if (acc_at_stall != 2 * N_PE || rdy_at_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_full: got accepted=%0d ready=%0b, want 32 0", acc_at_stall, rdy_at_stall);
        end
        n_tests++;
        if (stable_err != 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d unstable held cycles, want 0", stable_err);
        end
        n_tests++;
        if (timed_out || got_data.size() != exp_data.size() || done_cnt != 1) begin
            n_fail++;
            $display("FAIL stall_count: got %0d words done=%0d, want %0d words done=1",
                     got_data.size(), done_cnt, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_tests++;
            if ({got_last[i], got_strb[i], got_data[i]} !== {exp_last[i], exp_strb[i], exp_data[i]}) begin
                n_fail++;
                $display("FAIL stall_word%0d: got last=%0b strb=%h data=%h, want last=%0b strb=%h data=%h",
                         i, got_last[i], got_strb[i], got_data[i], exp_last[i], exp_strb[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        int valid_seen = 0;
        int done_extra = 0;
        start_i = 1'b1;
        len_i   = '0;
        @(negedge clk_i);
        n_tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_start: got done=%0b busy=%0b, want 0 0", done_o, busy_o);
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done=%0b busy=%0b valid=%0b, want 1 0 0", done_o, busy_o, valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (valid_o || busy_o) valid_seen++;
            if (done_o) done_extra++;
        end
        n_tests++;
        if (valid_seen != 0 || done_extra != 0) begin
            n_fail++;
            $display("FAIL zero_quiet: got active=%0d extra_done=%0d, want 0 0", valid_seen, done_extra);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        start_i = 1'b1;
        len_i   = LEN_W'(64);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1;
            data_i  = WI'($urandom);
            ready_i = 1'b1;
            @(negedge clk_i);
            if (valid_i && ready_o) acc++;
            @(posedge clk_i); #1;
        end
        n_tests++;
        if (acc != 10) begin
            n_fail++;
            $display("FAIL midrst_accept: got %0d accepted, want 10", acc);
        end
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        n_tests++;
        if ({valid_o, ready_o, busy_o, done_o, last_o, strb_o, data_o} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got v=%0b r=%0b busy=%0b done=%0b strb=%h data=%h, want all 0",
                     valid_o, ready_o, busy_o, done_o, strb_o, data_o);
        end
        rst_i   = 1'b0;
        ready_i = 1'b0;
        @(posedge clk_i); #1;
        fill_random(16);
        build_model(16);
        run_tile(16, 0, 1'b0, 1'b0);
        n_tests++;
        if (timed_out || got_data.size() != 1) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d words (timeout=%0b), want 1", got_data.size(), timed_out);
        end else begin
            n_tests++;
            if ({got_last[0], got_strb[0], got_data[0]} !== {exp_last[0], exp_strb[0], exp_data[0]}) begin
                n_fail++;
                $display("FAIL midrst_word: got last=%0b strb=%h data=%h, want last=%0b strb=%h data=%h",
                         got_last[0], got_strb[0], got_data[0], exp_last[0], exp_strb[0], exp_data[0]);
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(70, 1);
            fill_random(len);
            build_model(len);
            run_tile(len, 0, 1'b1, 1'b1);
            n_tests++;
            if (timed_out || got_data.size() != exp_data.size() || done_cnt != 1 || !done_on_last) begin
                n_fail++;
                $display("FAIL rand%0d_count: len=%0d got %0d words done=%0d on_last=%0b, want %0d words done=1 on_last=1",
                         t, len, got_data.size(), done_cnt, done_on_last, exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
                n_tests++;
                if ({got_last[i], got_strb[i], got_data[i]} !== {exp_last[i], exp_strb[i], exp_data[i]}) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d: got last=%0b strb=%h data=%h, want last=%0b strb=%h data=%h",
                             t, i, got_last[i], got_strb[i], got_data[i], exp_last[i], exp_strb[i], exp_data[i]);
                end
            end
            n_tests++;
            if (stable_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_stable: got %0d unstable held cycles, want 0", t, stable_err);
            end
        end
    endtask

`ifdef ITA_ACT_PACKER_CLIP_COUNT_EN
    task automatic test_clip();
        int want = 0;
        elems.delete();
        for (int i = 0; i < 16; i++) elems.push_back(WI'(int'($urandom_range(253)) - 127));
        elems[0]  = 8'sd127;
        elems[5]  = 8'sd127;
        elems[15] = 8'sd127;
        elems[3]  = -8'sd128;
        elems[9]  = -8'sd128;
        foreach (elems[i]) if (elems[i] == 8'sd127 || elems[i] == -8'sd128) want++;
        build_model(16);
        run_tile(16, 0, 1'b0, 1'b0);
        n_tests++;
        if (timed_out || done_cnt != 1 || clip_at_done !== LEN_W'(want)) begin
            n_fail++;
            $display("FAIL clip_count: got %0d (done=%0d), want %0d", clip_at_done, done_cnt, want);
        end
    endtask
`endif

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        len_i   = '0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        test_reset();
        test_full_tile();
        test_partial();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_random();
`ifdef ITA_ACT_PACKER_CLIP_COUNT_EN
        test_clip();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
